// File: rtl/int_ctrl_pkg.sv
// Shared types and constants for the interrupt controller.
// Optional nesting is enabled with INT_CTRL_NEST_EN.
package int_ctrl_pkg;

  localparam int NSRC = 4;

  localparam logic [1:0] SRC_IO0  = 2'd0;
  localparam logic [1:0] SRC_IO1  = 2'd1;
  localparam logic [1:0] SRC_CNT0 = 2'd2;
  localparam logic [1:0] SRC_CNT1 = 2'd3;

  localparam logic [NSRC-1:0] MASK_RST = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  function automatic logic [NSRC-1:0] onehot(input logic [1:0] i);
    onehot = NSRC'(1) << i;
  endfunction

endpackage

// File: rtl/int_ctrl_prio_enc.sv
// Fixed-priority encoder; bit 0 wins.
// Used for both pending selection and in-service lookup.
module int_prio_enc
  import int_ctrl_pkg::*;
(
  input  logic [NSRC-1:0] vec,
  output logic [1:0]      idx,
  output logic            vld
);

  always_comb begin
    idx = 2'd0;
    vld = |vec;
    priority case (1'b1)
      vec[0]:  idx = SRC_IO0;
      vec[1]:  idx = SRC_IO1;
      vec[2]:  idx = SRC_CNT0;
      vec[3]:  idx = SRC_CNT1;
      default: idx = 2'd0;
    endcase
  end

endmodule

// File: rtl/int_ctrl.sv
// Edge-capturing, masked, fixed-priority interrupt controller.
// Nesting by higher priority is enabled with INT_CTRL_NEST_EN.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter logic [31:0] IA1 = 32'h00000020,
  parameter logic [31:0] IA2 = 32'h00000020,
  parameter logic [31:0] IA3 = 32'h00000009,
  parameter logic [31:0] IA4 = 32'h00000009
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq,
  input  logic            mask_we,
  input  logic [NSRC-1:0] mask_wdata,
  input  logic            stall,
  input  logic            int_ack,
  input  logic            rti,
  output logic            int_req,
  output logic [31:0]     int_vec,
  output logic [1:0]      int_id,
  output logic [NSRC-1:0] int_taken,
  output logic [NSRC-1:0] pending,
  output logic [NSRC-1:0] in_service
);

  state_t          state;
  logic [NSRC-1:0] irq_q;
  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] eligible;
  logic [NSRC-1:0] acc_set;
  logic [NSRC-1:0] isr_clr;
  logic [1:0]      sel_idx;
  logic [1:0]      isr_idx;
  logic            sel_vld;
  logic            isr_vld;
  logic            gate;
  logic [31:0]     sel_vec;

  assign rise     = irq & ~irq_q;
  assign eligible = pending & mask;

  int_prio_enc u_sel (
    .vec (eligible),
    .idx (sel_idx),
    .vld (sel_vld)
  );

  int_prio_enc u_isr (
    .vec (in_service),
    .idx (isr_idx),
    .vld (isr_vld)
  );

`ifdef INT_CTRL_NEST_EN
  assign gate = !isr_vld || (sel_idx < isr_idx);
`else
  assign gate = !isr_vld;
`endif

  always_comb begin
    sel_vec = IA1;
    unique case (sel_idx)
      SRC_IO0:  sel_vec = IA1;
      SRC_IO1:  sel_vec = IA2;
      SRC_CNT0: sel_vec = IA3;
      SRC_CNT1: sel_vec = IA4;
      default:  sel_vec = IA1;
    endcase
  end

  // rti clear is applied before the acceptance set
  always_comb begin
    acc_set = '0;
    isr_clr = '0;
    if (state == REQ && int_ack) acc_set = onehot(int_id);
    if (rti && isr_vld) isr_clr = onehot(isr_idx);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      irq_q      <= '0;
      mask       <= MASK_RST;
      pending    <= '0;
      in_service <= '0;
      int_req    <= 1'b0;
      int_vec    <= '0;
      int_id     <= '0;
      int_taken  <= '0;
    end else begin
      irq_q      <= irq;
      pending    <= (pending & ~acc_set) | rise;
      in_service <= (in_service & ~isr_clr) | acc_set;
      if (mask_we) mask <= mask_wdata;
      unique case (state)
        IDLE: begin
          int_taken <= '0;
          if (sel_vld && gate && !stall) begin
            int_id  <= sel_idx;
            int_vec <= sel_vec;
            int_req <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          if (int_ack) begin
            int_req   <= 1'b0;
            int_taken <= acc_set;
            state     <= HOLD;
          end
        end
        HOLD: begin
          int_taken <= '0;
          state     <= IDLE;
        end
        default: begin
          int_req   <= 1'b0;
          int_taken <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed self-checking bench for int_ctrl.
// Define INT_CTRL_NEST_EN for both bench and RTL to check nesting.
module tb_int_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  irq;
  logic        mask_we;
  logic [3:0]  mask_wdata;
  logic        stall;
  logic        int_ack;
  logic        rti;
  logic        int_req;
  logic [31:0] int_vec;
  logic [1:0]  int_id;
  logic [3:0]  int_taken;
  logic [3:0]  pending;
  logic [3:0]  in_service;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  int_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .irq        (irq),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .stall      (stall),
    .int_ack    (int_ack),
    .rti        (rti),
    .int_req    (int_req),
    .int_vec    (int_vec),
    .int_id     (int_id),
    .int_taken  (int_taken),
    .pending    (pending),
    .in_service (in_service)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // accept current request, then step through HOLD
  task automatic accept();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    tick();
  endtask

  task automatic retire();
    rti = 1'b1;
    tick();
    rti = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    irq = '0; mask_we = 1'b0; mask_wdata = '0;
    stall = 1'b0; int_ack = 1'b0; rti = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    total++;
    if (int_req !== 1'b0) $display("FAIL rst_req got %b want 0", int_req);
    else passed++;
    total++;
    if (int_vec !== 32'h0) $display("FAIL rst_vec got %h want 0", int_vec);
    else passed++;
    total++;
    if ({int_id, int_taken, pending, in_service} !== 14'h0)
      $display("FAIL rst_state got %h want 0",
               {int_id, int_taken, pending, in_service});
    else passed++;
  endtask

  task automatic test_basic();
    irq = 4'b0100;
    tick();
    irq = 4'b0000;
    total++;
    if (pending !== 4'b0100 || int_req !== 1'b0)
      $display("FAIL basic_pend got %b/%b want 0100/0", pending, int_req);
    else passed++;
    tick();
    total++;
    if (int_req !== 1'b1 || int_id !== 2'd2 || int_vec !== 32'h9)
      $display("FAIL basic_req got %b/%0d/%h want 1/2/9",
               int_req, int_id, int_vec);
    else passed++;
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    total++;
    if (int_req !== 1'b0 || int_taken !== 4'b0100 ||
        in_service !== 4'b0100 || pending !== 4'b0000)
      $display("FAIL basic_ack got %b/%b/%b/%b want 0/0100/0100/0000",
               int_req, int_taken, in_service, pending);
    else passed++;
    tick();
    total++;
    if (int_taken !== 4'b0000)
      $display("FAIL basic_taken_pulse got %b want 0000", int_taken);
    else passed++;
    retire();
    total++;
    if (in_service !== 4'b0000)
      $display("FAIL basic_rti got %b want 0000", in_service);
    else passed++;
  endtask

  task automatic test_priority_nest();
    irq = 4'b1010;
    tick();
    irq = 4'b0000;
    tick();
    total++;
    if (int_req !== 1'b1 || int_id !== 2'd1 || int_vec !== 32'h20)
      $display("FAIL prio_first got %b/%0d/%h want 1/1/20",
               int_req, int_id, int_vec);
    else passed++;
    accept();
    total++;
    if (in_service !== 4'b0010 || pending !== 4'b1000)
      $display("FAIL prio_isr got %b/%b want 0010/1000",
               in_service, pending);
    else passed++;
    tick();
    total++;
    if (int_req !== 1'b0)
      $display("FAIL prio_gate got %b want 0", int_req);
    else passed++;
    retire();
    tick();
    total++;
    if (int_req !== 1'b1 || int_id !== 2'd3 || int_vec !== 32'h9)
      $display("FAIL prio_second got %b/%0d/%h want 1/3/9",
               int_req, int_id, int_vec);
    else passed++;
    accept();
    total++;
    if (in_service !== 4'b1000)
      $display("FAIL prio_isr3 got %b want 1000", in_service);
    else passed++;
    irq = 4'b0001;
    tick();
    irq = 4'b0000;
    tick();
`ifdef INT_CTRL_NEST_EN
    total++;
    if (int_req !== 1'b1 || int_id !== 2'd0)
      $display("FAIL nest_req got %b/%0d want 1/0", int_req, int_id);
    else passed++;
    accept();
    total++;
    if (in_service !== 4'b1001)
      $display("FAIL nest_isr got %b want 1001", in_service);
    else passed++;
    retire();
    total++;
    if (in_service !== 4'b1000)
      $display("FAIL nest_unwind got %b want 1000", in_service);
    else passed++;
    retire();
    total++;
    if (in_service !== 4'b0000)
      $display("FAIL nest_unwind2 got %b want 0000", in_service);
    else passed++;
`else
    tick();
    total++;
    if (int_req !== 1'b0)
      $display("FAIL nonest_block got %b want 0", int_req);
    else passed++;
    retire();
    total++;
    if (in_service !== 4'b0000)
      $display("FAIL nonest_rti got %b want 0000", in_service);
    else passed++;
    tick();
    total++;
    if (int_req !== 1'b1 || int_id !== 2'd0)
      $display("FAIL nonest_req got %b/%0d want 1/0", int_req, int_id);
    else passed++;
    accept();
    retire();
`endif
  endtask

  task automatic test_mask();
    mask_we = 1'b1; mask_wdata = 4'b1110;
    tick();
    mask_we = 1'b0;
    irq = 4'b0001;
    tick();
    irq = 4'b0000;
    total++;
    if (pending !== 4'b0001)
      $display("FAIL mask_pend got %b want 0001", pending);
    else passed++;
    tick(); tick();
    total++;
    if (int_req !== 1'b0)
      $display("FAIL mask_block got %b want 0", int_req);
    else passed++;
    mask_we = 1'b1; mask_wdata = 4'b1111;
    tick();
    mask_we = 1'b0;
    total++;
    if (int_req !== 1'b0)
      $display("FAIL mask_oldsel got %b want 0", int_req);
    else passed++;
    tick();
    total++;
    if (int_req !== 1'b1 || int_id !== 2'd0 || int_vec !== 32'h20)
      $display("FAIL mask_req got %b/%0d/%h want 1/0/20",
               int_req, int_id, int_vec);
    else passed++;
    accept();
    retire();
  endtask

  task automatic test_stall();
    stall = 1'b1;
    irq = 4'b0100;
    tick();
    irq = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (int_req !== 1'b0)
        $display("FAIL stall_hold%0d got %b want 0", i, int_req);
      else passed++;
    end
    stall = 1'b0;
    tick();
    total++;
    if (int_req !== 1'b1 || int_id !== 2'd2)
      $display("FAIL stall_release got %b/%0d want 1/2", int_req, int_id);
    else passed++;
    stall = 1'b1;
    mask_we = 1'b1; mask_wdata = 4'b0000;
    tick();
    mask_we = 1'b0;
    stall = 1'b0;
    total++;
    if (int_req !== 1'b1 || int_id !== 2'd2 || int_vec !== 32'h9)
      $display("FAIL req_frozen got %b/%0d/%h want 1/2/9",
               int_req, int_id, int_vec);
    else passed++;
    mask_we = 1'b1; mask_wdata = 4'b1111;
    tick();
    mask_we = 1'b0;
    int_ack = 1'b1;
    irq = 4'b0100;
    tick();
    int_ack = 1'b0;
    irq = 4'b0000;
    total++;
    if (pending !== 4'b0100 || in_service !== 4'b0100 ||
        int_taken !== 4'b0100)
      $display("FAIL edge_on_clear got %b/%b/%b want 0100/0100/0100",
               pending, in_service, int_taken);
    else passed++;
    tick();
    retire();
    tick();
    total++;
    if (int_req !== 1'b1 || int_id !== 2'd2)
      $display("FAIL repend_req got %b/%0d want 1/2", int_req, int_id);
    else passed++;
    accept();
    retire();
  endtask

  task automatic test_reset_mid();
    mask_we = 1'b1; mask_wdata = 4'b0001;
    tick();
    mask_we = 1'b0;
    irq = 4'b0001;
    tick();
    irq = 4'b0000;
    tick();
    total++;
    if (int_req !== 1'b1)
      $display("FAIL mid_pre got %b want 1", int_req);
    else passed++;
    irq = 4'b0010;
    #1 reset = 1'b1;
    #1;
    total++;
    if (int_req !== 1'b0 || pending !== 4'b0 || in_service !== 4'b0)
      $display("FAIL mid_async got %b/%b/%b want 0/0000/0000",
               int_req, pending, in_service);
    else passed++;
    irq = 4'b0000;
    tick();
    reset = 1'b0;
    tick();
    irq = 4'b0010;
    tick();
    irq = 4'b0000;
    tick();
    total++;
    if (int_req !== 1'b1 || int_id !== 2'd1)
      $display("FAIL mid_maskrst got %b/%0d want 1/1", int_req, int_id);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority_nest();
    test_mask();
    test_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

endmodule
